// File: rtl/relay_station_credit_if.sv
// Stream channel bundle for the credit-based relay station.
// The producer/consumer side uses the master modport; the relay station uses slave.
interface relay_station_credit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 4
);
    // Write side
    logic                  if_full_n;
    logic                  if_write_ce;
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;

    // Read side
    logic                  if_empty_n;
    logic                  if_read_ce;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;

    // Status
    logic [CNT_WIDTH-1:0]  if_credit;
    logic                  if_overflow;

    modport master (
        input  if_full_n,
        output if_write_ce,
        output if_write,
        output if_din,
        input  if_empty_n,
        output if_read_ce,
        output if_read,
        input  if_dout,
        input  if_credit,
        input  if_overflow
    );

    modport slave (
        output if_full_n,
        input  if_write_ce,
        input  if_write,
        input  if_din,
        output if_empty_n,
        input  if_read_ce,
        input  if_read,
        output if_dout,
        output if_credit,
        output if_overflow
    );
endinterface

// File: rtl/relay_station_credit.sv
// Credit-based relay station: LEVEL register stages carry data forward and
// credits back, and a DEPTH-entry FWFT buffer sits at the receiving end.
// The sender can only launch a word while it holds a credit, so the buffer
// cannot overflow for any LEVEL; the overflow flag only flags a broken design.
module relay_station_credit #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int LEVEL      = 2,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    relay_station_credit_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Sender side
    logic [CNT_WIDTH-1:0]  credit;
    logic                  full_n;
    logic                  acc;

    // Path endpoints
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  ret;

    // Receiver buffer
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         waddr;
    logic [AW-1:0]         raddr;
    logic [CNT_WIDTH-1:0]  used;
    logic                  empty_n;
    logic                  buf_full;
    logic                  pop;
    logic                  wr_en;
    logic                  drop;
    logic                  overflow;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_n = (credit != '0);
    assign acc    = bus.if_write & bus.if_write_ce & full_n;

    // Credit counter: spend on accept, regain on returned credit; both at once cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit <= CNT_WIDTH'(DEPTH);
        end else if (acc && !ret) begin
            credit <= credit - CNT_WIDTH'(1);
        end else if (!acc && ret) begin
            credit <= credit + CNT_WIDTH'(1);
        end
    end

    generate
        if (LEVEL == 0) begin : g_fwd_wire
            assign push      = acc;
            assign push_data = bus.if_din;
        end else begin : g_fwd_pipe
            logic [LEVEL-1:0]      fwd_valid;
            logic [DATA_WIDTH-1:0] fwd_data [LEVEL];

            // Forward valid bits: the only part of the data path that is reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    fwd_valid <= '0;
                end else begin
                    fwd_valid[0] <= acc;
                    for (int unsigned k = 1; k < LEVEL; k++) begin
                        fwd_valid[k] <= fwd_valid[k-1];
                    end
                end
            end

            // Forward data registers shift every cycle without reset.
            always_ff @(posedge clk) begin
                fwd_data[0] <= bus.if_din;
                for (int unsigned k = 1; k < LEVEL; k++) begin
                    fwd_data[k] <= fwd_data[k-1];
                end
            end

            assign push      = fwd_valid[LEVEL-1];
            assign push_data = fwd_data[LEVEL-1];
        end
    endgenerate

    generate
        if (LEVEL == 0) begin : g_ret_wire
            assign ret = pop;
        end else begin : g_ret_pipe
            logic [LEVEL-1:0] ret_valid;

            // Return path: one credit bit per pop, delayed LEVEL cycles.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ret_valid <= '0;
                end else begin
                    ret_valid[0] <= pop;
                    for (int unsigned k = 1; k < LEVEL; k++) begin
                        ret_valid[k] <= ret_valid[k-1];
                    end
                end
            end

            assign ret = ret_valid[LEVEL-1];
        end
    endgenerate

    assign empty_n  = (used != '0);
    assign buf_full = (used == CNT_WIDTH'(DEPTH));
    assign pop      = bus.if_read & bus.if_read_ce & empty_n;
    // A pop in the same cycle frees the slot a push into a full buffer needs.
    assign wr_en    = push & (~buf_full | pop);
    assign drop     = push & buf_full & ~pop;

    // Buffer storage: written on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= push_data;
        end
    end

    // Pointers and occupancy of the receiver buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            waddr <= '0;
            raddr <= '0;
            used  <= '0;
        end else begin
            if (wr_en) begin
                waddr <= bump(waddr);
            end
            if (pop) begin
                raddr <= bump(raddr);
            end
            if (wr_en && !pop) begin
                used <= used + CNT_WIDTH'(1);
            end else if (!wr_en && pop) begin
                used <= used - CNT_WIDTH'(1);
            end
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    assign bus.if_full_n   = full_n;
    assign bus.if_empty_n  = empty_n;
    assign bus.if_dout     = mem[raddr];
    assign bus.if_credit   = credit;
    assign bus.if_overflow = overflow;

endmodule

// File: tb/tb_relay_station_credit.sv
// Bench for relay_station_credit: three configurations (DEPTH/LEVEL = 4/2, 6/2,
// 1/0) share one stimulus stream and are compared every cycle against an
// event-timestamp reference model of credits, in-flight words and the buffer.
module tb_relay_station_credit;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          write_ce;
    logic          write;
    logic [DW-1:0] din;
    logic          read_ce;
    logic          read;

    relay_station_credit_if #(.DATA_WIDTH(DW), .CNT_WIDTH(3)) bus_a ();
    relay_station_credit_if #(.DATA_WIDTH(DW), .CNT_WIDTH(3)) bus_b ();
    relay_station_credit_if #(.DATA_WIDTH(DW), .CNT_WIDTH(1)) bus_c ();

    relay_station_credit #(.DATA_WIDTH(DW), .DEPTH(4), .LEVEL(2), .CNT_WIDTH(3)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    relay_station_credit #(.DATA_WIDTH(DW), .DEPTH(6), .LEVEL(2), .CNT_WIDTH(3)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );
    relay_station_credit #(.DATA_WIDTH(DW), .DEPTH(1), .LEVEL(0), .CNT_WIDTH(1)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c)
    );

    assign bus_a.if_write_ce = write_ce;
    assign bus_a.if_write    = write;
    assign bus_a.if_din      = din;
    assign bus_a.if_read_ce  = read_ce;
    assign bus_a.if_read     = read;
    assign bus_b.if_write_ce = write_ce;
    assign bus_b.if_write    = write;
    assign bus_b.if_din      = din;
    assign bus_b.if_read_ce  = read_ce;
    assign bus_b.if_read     = read;
    assign bus_c.if_write_ce = write_ce;
    assign bus_c.if_write    = write;
    assign bus_c.if_din      = din;
    assign bus_c.if_read_ce  = read_ce;
    assign bus_c.if_read     = read;

    logic          obs_full  [3];
    logic          obs_empty [3];
    logic          obs_ovf   [3];
    int            obs_credit[3];
    logic [DW-1:0] obs_dout  [3];

    assign obs_full[0]   = bus_a.if_full_n;
    assign obs_full[1]   = bus_b.if_full_n;
    assign obs_full[2]   = bus_c.if_full_n;
    assign obs_empty[0]  = bus_a.if_empty_n;
    assign obs_empty[1]  = bus_b.if_empty_n;
    assign obs_empty[2]  = bus_c.if_empty_n;
    assign obs_ovf[0]    = bus_a.if_overflow;
    assign obs_ovf[1]    = bus_b.if_overflow;
    assign obs_ovf[2]    = bus_c.if_overflow;
    assign obs_credit[0] = int'(bus_a.if_credit);
    assign obs_credit[1] = int'(bus_b.if_credit);
    assign obs_credit[2] = int'(bus_c.if_credit);
    assign obs_dout[0]   = bus_a.if_dout;
    assign obs_dout[1]   = bus_b.if_dout;
    assign obs_dout[2]   = bus_c.if_dout;

    // Per-configuration constants
    int    dep [3] = '{4, 6, 1};
    int    lev [3] = '{2, 2, 0};
    string nm  [3] = '{"d4l2", "d6l2", "d1l0"};

    // Reference model: credit count, timestamped in-flight words and credits,
    // and the receiver buffer as a plain queue.
    int            m_credit[3];
    bit            m_ovf   [3];
    logic [DW-1:0] m_buf   [3][$];
    int            fl_due  [3][$];
    logic [DW-1:0] fl_dat  [3][$];
    int            rt_due  [3][$];
    int            cyc;

    int            n_checks = 0;
    int            n_errors = 0;
    int            acc_cnt[3];
    int            pop_cnt[3];
    logic [DW-1:0] seq;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check({nm[i], "_full_n"},   64'(obs_full[i]),   64'(m_credit[i] != 0));
            check({nm[i], "_empty_n"},  64'(obs_empty[i]),  64'(m_buf[i].size() != 0));
            check({nm[i], "_credit"},   64'(obs_credit[i]), 64'(m_credit[i]));
            check({nm[i], "_overflow"}, 64'(obs_ovf[i]),    64'(m_ovf[i]));
            if (m_buf[i].size() != 0) begin
                check({nm[i], "_dout"}, 64'(obs_dout[i]), 64'(m_buf[i][0]));
            end
        end
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit            acc;
            bit            pop;
            bit            ret;
            int            pre;
            logic [DW-1:0] d;
            if (reset) begin
                m_credit[i] = dep[i];
                m_ovf[i]    = 1'b0;
                m_buf[i].delete();
                fl_due[i].delete();
                fl_dat[i].delete();
                rt_due[i].delete();
                continue;
            end
            acc = write && write_ce && (m_credit[i] != 0);
            pop = read && read_ce && (m_buf[i].size() != 0);
            if (acc) begin
                fl_due[i].push_back(cyc + lev[i]);
                fl_dat[i].push_back(din);
            end
            if (pop) rt_due[i].push_back(cyc + lev[i]);
            pre = m_buf[i].size();
            if (pop) void'(m_buf[i].pop_front());
            if (fl_due[i].size() != 0 && fl_due[i][0] == cyc) begin
                void'(fl_due[i].pop_front());
                d = fl_dat[i].pop_front();
                if (pre == dep[i] && !pop) m_ovf[i] = 1'b1;
                else m_buf[i].push_back(d);
            end
            ret = (rt_due[i].size() != 0 && rt_due[i][0] == cyc);
            if (ret) void'(rt_due[i].pop_front());
            m_credit[i] = m_credit[i] + int'(ret) - int'(acc);
        end
        cyc++;
    endtask

    // One clock cycle: check state at negedge, drive inputs, advance the model.
    task automatic cycle(input bit rst, input bit wce, input bit w, input bit rce, input bit r);
        @(negedge clk);
        compare_all();
        reset    = rst;
        write_ce = wce;
        write    = w;
        read_ce  = rce;
        read     = r;
        din      = w ? seq : $urandom();
        if (w) seq = seq + 1;
        for (int i = 0; i < 3; i++) begin
            if (!rst && obs_full[i] && w && wce) acc_cnt[i]++;
            if (!rst && obs_empty[i] && r && rce) pop_cnt[i]++;
        end
        model_edge();
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            acc_cnt[i] = 0;
            pop_cnt[i] = 0;
        end
    endtask

    initial begin
        cyc      = 0;
        seq      = 32'h1000_0000;
        reset    = 1'b1;
        write_ce = 1'b0;
        write    = 1'b0;
        read_ce  = 1'b0;
        read     = 1'b0;
        din      = '0;
        model_edge();
        repeat (2) @(posedge clk);

        // Idle after reset
        repeat (3) cycle(0, 0, 0, 0, 0);

        // Fill without reading
        clear_counts();
        repeat (10) cycle(0, 1, 1, 0, 0);
        check("fill_accepts_d4l2", 64'(acc_cnt[0]), 64'd4);
        check("fill_accepts_d6l2", 64'(acc_cnt[1]), 64'd6);
        check("fill_accepts_d1l0", 64'(acc_cnt[2]), 64'd1);

        // Drain, then let credits settle
        clear_counts();
        repeat (8) cycle(0, 0, 0, 1, 1);
        repeat (6) cycle(0, 0, 0, 0, 0);
        check("drain_pops_d4l2", 64'(pop_cnt[0]), 64'd4);

        // Throughput: continuous write and read from a clean reset
        cycle(1, 0, 0, 0, 0);
        clear_counts();
        repeat (1000) cycle(0, 1, 1, 1, 1);
        check("tput_accepts_d6l2", 64'(acc_cnt[1]), 64'd1000);
        check("tput_pops_d6l2", 64'(pop_cnt[1]), 64'd997);
        repeat (10) cycle(0, 0, 0, 1, 1);

        // Alternate write / read cycles
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) cycle(0, 1, 1, 0, 0);
            else            cycle(0, 0, 0, 1, 1);
        end

        // Clock-enable gating with requests held high
        repeat (4) cycle(0, 1, 1, 0, 0);
        repeat (5) cycle(0, 0, 0, 0, 0);
        clear_counts();
        repeat (6) cycle(0, 0, 1, 0, 1);
        check("ce_gated_accepts_d6l2", 64'(acc_cnt[1]), 64'd0);
        check("ce_gated_pops_d6l2", 64'(pop_cnt[1]), 64'd0);
        repeat (10) cycle(0, 0, 0, 1, 1);

        // Randomized traffic with occasional reset
        for (int k = 0; k < 300; k++) begin
            cycle(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1));
        end

        // Reset while words are in flight and buffered; nothing stale may surface
        cycle(1, 0, 0, 0, 0);
        repeat (5) cycle(0, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        clear_counts();
        repeat (10) cycle(0, 0, 0, 1, 1);
        check("post_reset_pops_d6l2", 64'(pop_cnt[1]), 64'd0);

        @(negedge clk);
        compare_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
